// File: rtl/cpu_pkg.sv
// cpu_pkg: FSM states, ISA encodings, vsel codes and instruction field helpers
package cpu_pkg;
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG} state_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] VSEL_C = 2'b00;
  localparam logic [1:0] VSEL_PC = 2'b01;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  function automatic logic [2:0] opcode_of(input logic [15:0] i); return i[15:13]; endfunction
  function automatic logic [1:0] op_of(input logic [15:0] i); return i[12:11]; endfunction
  function automatic logic [2:0] rn_of(input logic [15:0] i); return i[10:8]; endfunction
  function automatic logic [2:0] rd_of(input logic [15:0] i); return i[7:5]; endfunction
  function automatic logic [1:0] sh_of(input logic [15:0] i); return i[4:3]; endfunction
  function automatic logic [2:0] rm_of(input logic [15:0] i); return i[2:0]; endfunction
  function automatic logic [15:0] sext8(input logic [15:0] i); return {{8{i[7]}}, i[7:0]}; endfunction
  function automatic logic [15:0] sext5(input logic [15:0] i); return {{11{i[4]}}, i[4:0]}; endfunction
endpackage

// File: rtl/instr_dec.sv
// instr_dec: splits the instruction register into fields, immediates and a legality flag
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        legal
);
  always_comb begin
    opcode = opcode_of(ir);
    op     = op_of(ir);
    rn     = rn_of(ir);
    rd     = rd_of(ir);
    rm     = rm_of(ir);
    sh     = sh_of(ir);
    sximm5 = sext5(ir);
    sximm8 = sext8(ir);
    legal  = opcode == OPC_ALU || (opcode == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG));
  end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus sequencing FSM driving the datapath controls
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          write,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);
  state_t state, nxt;
  logic [IW-1:0] ir;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic legal, is_cmp, is_mov;
  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (shift),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .legal  (legal)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (load && w) ir <= in;
    end
  always_comb begin
    is_cmp   = opcode == OPC_ALU && op == OP_CMP;
    is_mov   = opcode == OPC_MOV;
    nxt      = state == WAIT   ? (s ? DECODE : WAIT) :
               state == DECODE ? (!legal ? WAIT : is_mov ? (op == OP_MOV_IMM ? WRITE_IMM : GET_B) :
                                  op == OP_MVN ? GET_B : GET_A) :
               state == GET_A  ? GET_B :
               state == GET_B  ? ALU :
               state == ALU && !is_cmp ? WRITE_REG : WAIT;
    w        = state == WAIT;
    readnum  = state == GET_B ? rm : rn;
    writenum = state == WRITE_IMM ? rn : rd;
    vsel     = state == WRITE_IMM ? VSEL_IMM8 : VSEL_C;
    loada    = state == GET_A;
    loadb    = state == GET_B;
    loadc    = state == ALU && !is_cmp;
    loads    = state == ALU && is_cmp;
    asel     = state == ALU && is_mov;
    bsel     = 1'b0;
    ALUop    = op;
    write    = state == WRITE_IMM || state == WRITE_REG;
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: randomized scoreboard bench with a behavioural datapath and ISA-level reference
module tb_cpu_controller;
  logic clk = 0, reset_n = 1, load = 0, s = 0;
  logic [15:0] in = 0;
  logic w, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0] readnum, writenum;
  logic [1:0] vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cpu_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .write(write), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );
  logic [15:0] rf [8] = '{default: 16'h0};
  logic [15:0] ra = 0, rb = 0, rc = 0, ain, bin, res;
  logic [2:0] st = 0;
  logic ovf;
  always_comb begin
    ain = asel ? 16'h0 : ra;
    bin = bsel ? sximm5 : shift == 2'b01 ? {rb[14:0], 1'b0} : shift == 2'b10 ? {1'b0, rb[15:1]} :
          shift == 2'b11 ? {rb[15], rb[15:1]} : rb;
    res = ALUop == 2'b00 ? ain + bin : ALUop == 2'b01 ? ain - bin : ALUop == 2'b10 ? ain & bin : ~bin;
    ovf = (ain[15] != bin[15]) && (res[15] != ain[15]);
  end
  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel == 2'b10 ? sximm8 : vsel == 2'b00 ? rc : 16'h0;
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= res;
    if (loads) st <= {ovf, res[15], res == 16'h0};
  end
  logic [15:0] m [8] = '{default: 16'h0};
  logic [2:0] mst = 0;
  typedef struct packed {logic [7:0] lat; logic [127:0] regs; logic [2:0] st;} exp_t;
  exp_t sb[$];
  function automatic logic [127:0] pk(input logic [15:0] r [8]);
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[k*16 +: 16] = r[k];
    return p;
  endfunction
  function automatic logic [7:0] ref_exec(input logic [15:0] i);
    logic [15:0] a, b, sb2;
    int d;
    a = m[i[10:8]];
    b = m[i[2:0]];
    case (i[4:3])
      2'd0: sb2 = b;
      2'd1: sb2 = b * 2;
      2'd2: sb2 = b / 2;
      default: sb2 = b / 2 + (b & 16'h8000);
    endcase
    if (i[15:11] == 5'b11010) begin
      d = $signed(i[7:0]);
      m[i[10:8]] = d[15:0];
      return 3;
    end
    if (i[15:11] == 5'b11000) begin
      m[i[7:5]] = sb2;
      return 5;
    end
    if (i[15:13] == 3'b101)
      case (i[12:11])
        2'd0: begin m[i[7:5]] = a + sb2; return 6; end
        2'd1: begin
          d = $signed(a) - $signed(sb2);
          mst = {d > 32767 || d < -32768, d[15], d[15:0] == 16'h0};
          return 5;
        end
        2'd2: begin m[i[7:5]] = a & sb2; return 6; end
        default: begin m[i[7:5]] = ~sb2; return 5; end
      endcase
    return 2;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  task automatic push(input logic [15:0] i);
    exp_t e;
    e.lat = ref_exec(i);
    e.regs = pk(m);
    e.st = mst;
    sb.push_back(e);
  endtask
  initial begin
    exp_t e;
    bit pw;
    int t0;
    pw = 1;
    t0 = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) pw = 1;
      else begin
        if (pw && !w) t0 = cyc;
        if (!pw && w) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got completion want none");
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - t0 + 1, e.lat);
            chk("regs", pk(rf), e.regs);
            chk("status", st, e.st);
          end
        end
        pw = w;
      end
    end
  end
  function automatic logic [18:0] ctl_now();
    return {write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum, ALUop, shift};
  endfunction
  function automatic logic [18:0] cv(logic wr, la, lb, lc, ls, as, logic [1:0] vs, logic [2:0] rn, wn,
                                     logic [1:0] aop, sh);
    return {wr, la, lb, lc, ls, as, 1'b0, vs, rn, wn, aop, sh};
  endfunction
  task automatic chkc(input string nm, input logic [18:0] want);
    chk(nm, ctl_now(), want);
    @(negedge clk);
  endtask
  task automatic wait_idle(input bit junk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      load = 0;
      s = 0;
      if (w) return;
      if (junk && $urandom_range(2) == 0) begin
        in = $urandom;
        load = 1;
        s = 1;
      end
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: got w=0 want w=1 within 60 cycles");
  endtask
  task automatic issue(input logic [15:0] i, input bit p);
    wait_idle(0);
    in = i;
    load = 1;
    s = 1;
    if (p) push(i);
    @(negedge clk);
    load = 0;
    s = 0;
  endtask
  initial begin
    logic [15:0] r;
    int kind;
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] r;
    int kind;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_w", w, 1);
    chk("reset_ir", dut.ir, 0);
    chk("reset_ctl", ctl_now(), cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1;
    issue(16'hD007, 1);
    chkc("movi_decode", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    chk("movi_sximm8", sximm8, 16'h0007);
    chkc("movi_write", cv(1, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0));
    issue(16'hD102, 1);
    issue(16'hA148, 1);
    chkc("add_decode", cv(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1));
    chkc("add_get_a", cv(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1));
    chkc("add_get_b", cv(0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1));
    chkc("add_alu", cv(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 1));
    chkc("add_write", cv(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1));
    issue(16'hD320, 1);
    issue(16'hAA13, 1);
    chkc("cmp_decode", cv(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2));
    chkc("cmp_get_a", cv(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2));
    chkc("cmp_get_b", cv(0, 0, 1, 0, 0, 0, 0, 3, 0, 1, 2));
    chkc("cmp_alu", cv(0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 2));
    chk("cmp_idle", w, 1);
    issue(16'hD5CE, 1);
    chk("neg_sximm8", sximm8, 16'hFFCE);
    issue(16'hB8E0, 1);
    issue(16'hC0C5, 1);
    chkc("movr_decode", cv(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0));
    chkc("movr_get_b", cv(0, 0, 1, 0, 0, 0, 0, 5, 6, 0, 0));
    chkc("movr_alu", cv(0, 0, 0, 1, 0, 1, 0, 0, 6, 0, 0));
    chkc("movr_write", cv(1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0));
    issue(16'hA148, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_w", w, 1);
    chk("rst_mid_write", write, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    chk("rst_mid_ir", dut.ir, 0);
    chk("rst_mid_idle", w, 1);
    issue(16'hD7AA, 0);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_cancel_write", write, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    issue(16'hA148, 1);
    in = 16'hFFFF;
    load = 1;
    s = 1;
    @(negedge clk);
    load = 0;
    s = 0;
    chk("busy_load_ir", dut.ir, 16'hA148);
    issue(16'hE000, 1);
    chk("illegal_no_write", write, 0);
    wait_idle(0);
    in = 16'hA481;
    load = 1;
    s = 1;
    push(16'hA481);
    push(16'hA481);
    @(negedge clk);
    load = 0;
    for (int k = 0; k < 30 && !w; k++) @(negedge clk);
    @(negedge clk);
    s = 0;
    repeat (40) begin
      kind = $urandom_range(6);
      r = $urandom;
      if (kind == 0) r[15:11] = 5'b11010;
      else if (kind == 1) r[15:11] = 5'b11000;
      else if (kind < 6) r[15:13] = 3'b101;
      else while (r[15:13] == 3'b101 || (r[15:13] == 3'b110 && !r[11])) r = $urandom;
      issue(r, 1);
      wait_idle(1);
    end
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
